tuple_hasher: RTL and testbench
===============================

# tuple_hasher

Upstream neighbour of the Bloom-filter update stage. Accepts one 96-bit flow tuple plus an ack flag per transaction. Computes two independent CRC-32 hashes over the direction-normalised tuple, 8 bits per cycle. Presents `{is_ack, tuple, index_0, index_1}` to the Bloom filter through its `in_wr`/`in_rdy` handshake.

## Interface
Parameters:
- `SRAM_ADDR_WIDTH`, 19: width of `index_0`/`index_1`; each index is the low bits of its CRC. Legal range 1..32.
- `TUPLE_WIDTH`, 96: fixed; any other value is illegal.

Ports:
- `clk`  in  1  single clock; all logic on rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `in_vld`  in  1  upstream tuple valid.
- `in_rdy`  out  1  block can accept a tuple.
- `in_tuple`  in  96  `{ip_src[95:64], ip_dst[63:32], port_src[31:16], port_dst[15:0]}`.
- `in_is_ack`  in  1  tuple taken from a pure-ACK packet.
- `out_wr`  out  1  drives Bloom filter `in_wr`.
- `out_rdy`  in  1  from Bloom filter `in_rdy`.
- `is_ack`  out  1  latched ack flag.
- `tuple`  out  96  normalised tuple.
- `index_0`  out  SRAM_ADDR_WIDTH  hash A (CRC-32, poly 0x04C11DB7).
- `index_1`  out  SRAM_ADDR_WIDTH  hash B (CRC-32C, poly 0x1EDC6F41).

## Operation
- States: IDLE, HASH, OUT. One-hot encoding.
- `in_rdy = (state == IDLE)`. Transfer occurs when `in_vld && in_rdy`.
- **IDLE**, on transfer:
  - Latch `is_ack`.
  - Latch the tuple: unchanged for data tuples. For ack tuples, latch it swapped to `{ip_dst, ip_src, port_dst, port_src}`, so an ACK hashes to the same indices as its data flow.
  - Load both CRC registers with 32'hFFFFFFFF and clear `byte_cnt` (4 bits).
  - Go to HASH.
- **HASH**, every cycle:
  - Feed byte `tuple[95-8*byte_cnt -: 8]` (MSB first, non-reflected) into both CRC steps and increment `byte_cnt`.
  - After the byte with `byte_cnt == 11`, go to OUT.
  - On that same edge, register `index_0 = crcA_next[SRAM_ADDR_WIDTH-1:0]` and `index_1` likewise from CRC B. No final XOR is applied.
- **OUT**:
  - `out_wr = (state == OUT) && out_rdy` (combinational).
  - When `out_wr` is high, go to IDLE.
  - While `out_rdy` is low, hold OUT with all outputs stable.
- `in_vld` is ignored outside IDLE. No tuple is ever dropped.

## Timing
- Reset values: state IDLE, `in_rdy` 1, `out_wr` 0, `is_ack` 0, `tuple` 0, `index_0` 0, `index_1` 0, CRCs 0, `byte_cnt` 0.
- Latency:
  - Transfer on edge E0.
  - HASH occupies the cycles after E0..E11.
  - OUT is entered at E12, so `out_wr` can be high in cycle 13.
  - Minimum initiation interval is 14 cycles.
- Reset asserted mid-HASH or mid-OUT:
  - All state clears immediately (asynchronous) and the partial tuple is discarded.
  - `out_wr` drops in the same cycle.
- `out_rdy` toggling in OUT: exactly one `out_wr` pulse per tuple, in the first cycle `out_rdy` is high.
- `in_rdy` rises combinationally in the cycle after the `out_wr` pulse.

## Configuration
- Macro `TUPLE_HASHER_DISTINCT_IDX_EN`.
- Defined: if the registered `index_1` would equal `index_0`, `index_1` is replaced by `index_0 ^ 1` (LSB flip), computed on the same edge with no extra latency. This guarantees two distinct Bloom cells.
- Undefined: indices are raw CRC low bits and may be equal.

## Structure
- Shared package `bloom_pkg` holds:
  - `TUPLE_WIDTH` (96).
  - `CRC_POLY_A` (32'h04C11DB7) and `CRC_POLY_B` (32'h1EDC6F41).
  - `CRC_SEED` (32'hFFFFFFFF).
  - `HASH_BYTES` (12).
  - The state encoding.
- Sub-module `crc32_byte_step`: purely combinational 8-bit CRC update, parameterised by polynomial; inputs `crc_in[31:0]`, `data[7:0]`; output `crc_out[31:0]`. Instantiated twice.

## Test plan
- Reset then idle: after `reset` deasserts, `in_rdy` = 1, `out_wr` = 0 and all outputs are 0 for 20 cycles.
- Single data tuple 96'h0A000001_0A000002_1F90_C350 with `out_rdy` = 1:
  - `out_wr` is high exactly once, 13 cycles after transfer.
  - `tuple` is unchanged and `is_ack` = 0.
  - Indices match the software CRC model (seed FFFFFFFF, MSB-first, no final XOR).
- ACK symmetry: send ack tuple 96'h0A000002_0A000001_C350_1F90.
  - `tuple` output is 96'h0A000001_0A000002_1F90_C350.
  - `index_0`/`index_1` are identical to the previous data case and `is_ack` = 1.
- Backpressure: hold `out_rdy` = 0 for 30 cycles in OUT.
  - Outputs stay stable, `in_rdy` = 0, and the held `in_vld` is not accepted.
  - Releasing `out_rdy` gives one `out_wr` pulse, then the next tuple is accepted.
- Reset mid-HASH: pulse `reset` low at hash byte 5.
  - All outputs are 0 at once and no `out_wr` appears.
  - The next tuple completes with a correct 13-cycle latency.
- `TUPLE_HASHER_DISTINCT_IDX_EN` with `SRAM_ADDR_WIDTH` = 2:
  - Sweep tuples until raw indices collide, then check `index_1 == index_0 ^ 1`.
  - With the macro undefined, equal indices pass through unchanged.

Source files
------------

// File: rtl/bloom_pkg.sv
// Shared constants, state encoding and tuple helpers for the Bloom-filter front end.
package bloom_pkg;

  localparam int          TUPLE_WIDTH = 96;
  localparam logic [31:0] CRC_POLY_A  = 32'h04C11DB7;
  localparam logic [31:0] CRC_POLY_B  = 32'h1EDC6F41;
  localparam logic [31:0] CRC_SEED    = 32'hFFFFFFFF;
  localparam int          HASH_BYTES  = 12;

  typedef enum logic [2:0] {
    ST_IDLE = 3'b001,
    ST_HASH = 3'b010,
    ST_OUT  = 3'b100
  } state_t;

  // An ACK travels in the reverse direction; swapping endpoints maps it onto its data flow.
  function automatic logic [TUPLE_WIDTH-1:0] swap_direction(input logic [TUPLE_WIDTH-1:0] t);
    return {t[63:32], t[95:64], t[15:0], t[31:16]};
  endfunction

endpackage

// File: rtl/tuple_hasher_crc32_byte_step.sv
// One byte of a non-reflected, MSB-first CRC-32 update; purely combinational.
module crc32_byte_step #(
  parameter logic [31:0] POLY = 32'h04C11DB7
) (
  input  logic [31:0] crc_in,
  input  logic [7:0]  data,
  output logic [31:0] crc_out
);

  logic [8:0][31:0] stage;

  assign stage[0] = crc_in;

  generate
    for (genvar gi = 0; gi < 8; gi++) begin : g_bit
      logic fb;
      assign fb           = stage[gi][31] ^ data[7-gi];
      assign stage[gi+1]  = {stage[gi][30:0], 1'b0} ^ (fb ? POLY : 32'h0);
    end
  endgenerate

  assign crc_out = stage[8];

endmodule

// File: rtl/tuple_hasher.sv
// Direction-normalises a 96-bit flow tuple and hashes it with CRC-32 and CRC-32C, one byte per cycle.
// Optional macro TUPLE_HASHER_DISTINCT_IDX_EN forces index_1 != index_0 by flipping its LSB.
module tuple_hasher #(
  parameter int SRAM_ADDR_WIDTH = 19,
  parameter int TUPLE_WIDTH     = 96
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       in_vld,
  output logic                       in_rdy,
  input  logic [TUPLE_WIDTH-1:0]     in_tuple,
  input  logic                       in_is_ack,
  output logic                       out_wr,
  input  logic                       out_rdy,
  output logic                       is_ack,
  output logic [TUPLE_WIDTH-1:0]     tuple,
  output logic [SRAM_ADDR_WIDTH-1:0] index_0,
  output logic [SRAM_ADDR_WIDTH-1:0] index_1
);
  import bloom_pkg::*;

  state_t                     state_reg, state_next;
  logic [3:0]                 byte_cnt_reg;
  logic [31:0]                crc_a_reg, crc_b_reg;
  logic [31:0]                crc_a_next, crc_b_next;
  logic [TUPLE_WIDTH-1:0]     tuple_reg;
  logic                       is_ack_reg;
  logic [SRAM_ADDR_WIDTH-1:0] index_0_reg, index_1_reg;
  logic [SRAM_ADDR_WIDTH-1:0] idx_0_next, idx_1_next, idx_1_raw;
  logic [7:0]                 byte_sel;
  logic                       last_byte;
  logic                       xfer;

  assign last_byte = (byte_cnt_reg == 4'(HASH_BYTES - 1));
  assign xfer      = in_vld && in_rdy;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_reg <= ST_IDLE;
    else        state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    in_rdy     = 1'b0;
    out_wr     = 1'b0;
    unique case (state_reg)
      ST_IDLE: begin
        in_rdy = 1'b1;
        if (in_vld) state_next = ST_HASH;
      end
      ST_HASH: begin
        if (last_byte) state_next = ST_OUT;
      end
      ST_OUT: begin
        out_wr = out_rdy;
        if (out_rdy) state_next = ST_IDLE;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  // MSB-first byte walk over the latched tuple.
  always_comb begin
    byte_sel = 8'h00;
    for (int i = 0; i < HASH_BYTES; i++) begin
      if (byte_cnt_reg == 4'(i)) byte_sel = tuple_reg[TUPLE_WIDTH-1-8*i -: 8];
    end
  end

  crc32_byte_step #(.POLY(CRC_POLY_A)) u_crc_a (
    .crc_in  (crc_a_reg),
    .data    (byte_sel),
    .crc_out (crc_a_next)
  );

  crc32_byte_step #(.POLY(CRC_POLY_B)) u_crc_b (
    .crc_in  (crc_b_reg),
    .data    (byte_sel),
    .crc_out (crc_b_next)
  );

  assign idx_0_next = crc_a_next[SRAM_ADDR_WIDTH-1:0];
  assign idx_1_raw  = crc_b_next[SRAM_ADDR_WIDTH-1:0];

`ifdef TUPLE_HASHER_DISTINCT_IDX_EN
  // Two distinct Bloom cells per key: break a collision by flipping the LSB.
  assign idx_1_next = (idx_1_raw == idx_0_next) ? (idx_0_next ^ SRAM_ADDR_WIDTH'(1)) : idx_1_raw;
`else
  assign idx_1_next = idx_1_raw;
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      byte_cnt_reg <= 4'd0;
      crc_a_reg    <= 32'h0;
      crc_b_reg    <= 32'h0;
      tuple_reg    <= '0;
      is_ack_reg   <= 1'b0;
      index_0_reg  <= '0;
      index_1_reg  <= '0;
    end else if (xfer) begin
      byte_cnt_reg <= 4'd0;
      crc_a_reg    <= CRC_SEED;
      crc_b_reg    <= CRC_SEED;
      tuple_reg    <= in_is_ack ? swap_direction(in_tuple) : in_tuple;
      is_ack_reg   <= in_is_ack;
    end else if (state_reg == ST_HASH) begin
      byte_cnt_reg <= byte_cnt_reg + 4'd1;
      crc_a_reg    <= crc_a_next;
      crc_b_reg    <= crc_b_next;
      if (last_byte) begin
        index_0_reg <= idx_0_next;
        index_1_reg <= idx_1_next;
      end
    end
  end

  assign is_ack  = is_ack_reg;
  assign tuple   = tuple_reg;
  assign index_0 = index_0_reg;
  assign index_1 = index_1_reg;

endmodule

// File: tb/tb_tuple_hasher.sv
// Randomised self-checking bench: two hasher instances (wide and 2-bit index) against a bit-serial CRC model.
module tb_tuple_hasher;

  localparam int W_A = 19;
  localparam int W_B = 2;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          in_vld = 1'b0;
  logic [95:0]   in_tuple = '0;
  logic          in_is_ack = 1'b0;
  logic          out_rdy = 1'b0;

  logic          in_rdy_a, out_wr_a, is_ack_a;
  logic [95:0]   tuple_a;
  logic [W_A-1:0] index_0_a, index_1_a;
  logic          in_rdy_b, out_wr_b, is_ack_b;
  logic [95:0]   tuple_b;
  logic [W_B-1:0] index_0_b, index_1_b;

  int checks = 0;
  int failures = 0;
  int tx_num = 0;
  int collisions = 0;

  always #5 clk = ~clk;

  tuple_hasher #(.SRAM_ADDR_WIDTH(W_A), .TUPLE_WIDTH(96)) dut_a (
    .clk(clk), .reset(reset), .in_vld(in_vld), .in_rdy(in_rdy_a),
    .in_tuple(in_tuple), .in_is_ack(in_is_ack), .out_wr(out_wr_a), .out_rdy(out_rdy),
    .is_ack(is_ack_a), .tuple(tuple_a), .index_0(index_0_a), .index_1(index_1_a)
  );

  tuple_hasher #(.SRAM_ADDR_WIDTH(W_B), .TUPLE_WIDTH(96)) dut_b (
    .clk(clk), .reset(reset), .in_vld(in_vld), .in_rdy(in_rdy_b),
    .in_tuple(in_tuple), .in_is_ack(in_is_ack), .out_wr(out_wr_b), .out_rdy(out_rdy),
    .is_ack(is_ack_b), .tuple(tuple_b), .index_0(index_0_b), .index_1(index_1_b)
  );

  task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Whole 96-bit message as one MSB-first bit stream, seed all-ones, no final XOR.
  function automatic logic [31:0] crc_ref(input logic [31:0] poly, input logic [95:0] msg);
    logic [31:0] c = 32'hFFFFFFFF;
    for (int i = 95; i >= 0; i--) begin
      logic fb;
      fb = c[31] ^ msg[i];
      c  = {c[30:0], 1'b0} ^ (fb ? poly : 32'h0);
    end
    return c;
  endfunction

  function automatic logic [31:0] pick_idx1(input logic [31:0] i0, input logic [31:0] i1);
`ifdef TUPLE_HASHER_DISTINCT_IDX_EN
    if (i1 == i0) return i0 ^ 32'd1;
`endif
    return i1;
  endfunction

  task automatic check_idle_zero(input string tag);
    check_eq({tag, "_in_rdy"}, {in_rdy_a, in_rdy_b}, 2'b11);
    check_eq({tag, "_out_wr"}, {out_wr_a, out_wr_b}, 2'b00);
    check_eq({tag, "_is_ack"}, {is_ack_a, is_ack_b}, 2'b00);
    check_eq({tag, "_tuple"}, {tuple_a, tuple_b[31:0]}, 128'h0);
    check_eq({tag, "_index"}, {index_0_a, index_1_a, index_0_b, index_1_b}, 0);
  endtask

  // Sends one tuple and follows it through HASH and OUT; hold = cycles out_rdy stays low in OUT.
  task automatic run_tuple(input logic [95:0] t, input logic ack, input int hold);
    logic [95:0] nt;
    logic [31:0] ca, cb, e0a, e1a, e0b, e1b;
    int done_c;
    nt  = ack ? {t[63:32], t[95:64], t[15:0], t[31:16]} : t;
    ca  = crc_ref(32'h04C11DB7, nt);
    cb  = crc_ref(32'h1EDC6F41, nt);
    e0a = ca & ((32'd1 << W_A) - 1);
    e1a = pick_idx1(e0a, cb & ((32'd1 << W_A) - 1));
    e0b = ca & 32'd3;
    e1b = pick_idx1(e0b, cb & 32'd3);
    if ((ca & 32'd3) == (cb & 32'd3)) collisions++;
    done_c = 13 + hold;

    check_eq("in_rdy_start", {in_rdy_a, in_rdy_b}, 2'b11);
    in_vld    = 1'b1;
    in_tuple  = t;
    in_is_ack = ack;
    out_rdy   = (hold == 0) ? 1'b0 : 1'b0;
    for (int c = 1; c <= done_c + 1; c++) begin
      @(negedge clk);
      // keep a junk request asserted; it must be ignored outside IDLE
      in_tuple  = {$urandom, $urandom, $urandom};
      in_is_ack = 1'($urandom_range(0, 1));
      out_rdy   = (c >= done_c);
      if (c >= done_c) in_vld = 1'b0;
      #1;
      if (c <= done_c) begin
        check_eq("out_wr_timing", {out_wr_a, out_wr_b}, (c == done_c) ? 2'b11 : 2'b00);
        check_eq("in_rdy_busy", {in_rdy_a, in_rdy_b}, 2'b00);
      end
      if (c >= 13 && c <= done_c) begin
        check_eq("tuple_a", tuple_a, nt);
        check_eq("tuple_b", tuple_b, nt);
        check_eq("is_ack", {is_ack_a, is_ack_b}, {ack, ack});
        check_eq("index_0_a", index_0_a, e0a);
        check_eq("index_1_a", index_1_a, e1a);
        check_eq("index_0_b", index_0_b, e0b);
        check_eq("index_1_b", index_1_b, e1b);
      end
      if (c == done_c + 1) begin
        check_eq("out_wr_after", {out_wr_a, out_wr_b}, 2'b00);
        check_eq("in_rdy_after", {in_rdy_a, in_rdy_b}, 2'b11);
      end
    end
    tx_num++;
    $display("tx %0d tuple=%h ack=%0d hold=%0d idx0=%h idx1=%h idx0_w2=%0d idx1_w2=%0d",
             tx_num, t, ack, hold, e0a[W_A-1:0], e1a[W_A-1:0], e0b, e1b);
  endtask

  task automatic reset_mid_hash(input logic [95:0] t);
    in_vld    = 1'b1;
    in_tuple  = t;
    in_is_ack = 1'b0;
    out_rdy   = 1'b1;
    for (int c = 1; c <= 6; c++) begin
      @(negedge clk);
      in_vld = 1'b0;
    end
    reset = 1'b0;
    #1;
    check_idle_zero("mid_hash_reset");
    @(negedge clk);
    reset = 1'b1;
    for (int c = 0; c < 16; c++) begin
      @(negedge clk);
      #1;
      check_eq("no_out_wr_after_reset", {out_wr_a, out_wr_b}, 2'b00);
    end
    tx_num++;
    $display("tx %0d tuple=%h aborted by reset at hash byte 5", tx_num, t);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    reset = 1'b1;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      #1;
      check_idle_zero("reset_idle");
    end

    run_tuple(96'h0A000001_0A000002_1F90_C350, 1'b0, 0);
    run_tuple(96'h0A000002_0A000001_C350_1F90, 1'b1, 0);
    run_tuple({$urandom, $urandom, $urandom}, 1'b0, 30);
    run_tuple({$urandom, $urandom, $urandom}, 1'b1, 0);
    reset_mid_hash({$urandom, $urandom, $urandom});
    run_tuple({$urandom, $urandom, $urandom}, 1'b0, 0);

    for (int n = 0; n < 40; n++) begin
      run_tuple({$urandom, $urandom, $urandom}, 1'($urandom_range(0, 1)),
                int'($urandom_range(0, 3)));
    end

    $display("2-bit index collisions exercised: %0d", collisions);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
